// File: rtl/gyro_motion_filter.sv
// gyro_motion_filter: zero-rate bias calibration, dead-banded rate correction,
// saturating angle integration and hysteretic tilt flags for a 3-axis gyro.
// Samples on an internal tick since the SPI controller provides no valid strobe.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   x/y/z_axis_data             raw signed gyro samples
//   recal, zero_angles          control pulses
//   calibrated                  bias valid (state RUN)
//   x/y/z_rate                  signed corrected rates
//   x/y/z_angle                 signed integrated angles (ANGLE_W bits)
//   sample_strobe               1-cycle pulse when rates/angles update
//   tilt_left/right/fwd/back    hysteretic roll/pitch flags
module gyro_motion_filter #(
    parameter int unsigned SAMPLE_DIV = 1_000_000,
    parameter int unsigned CAL_LOG2   = 6,
    parameter int unsigned DEADBAND   = 16,
    parameter int unsigned RATE_SHIFT = 4,
    parameter int unsigned ANGLE_W    = 24,
    parameter int unsigned ANGLE_MAX  = 4_000_000,
    parameter int unsigned TILT_ON    = 20000,
    parameter int unsigned TILT_OFF   = 12000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [15:0]        x_axis_data,
    input  logic signed [15:0]        y_axis_data,
    input  logic signed [15:0]        z_axis_data,
    input  logic                      recal,
    input  logic                      zero_angles,
    output logic                      calibrated,
    output logic signed [15:0]        x_rate,
    output logic signed [15:0]        y_rate,
    output logic signed [15:0]        z_rate,
    output logic signed [ANGLE_W-1:0] x_angle,
    output logic signed [ANGLE_W-1:0] y_angle,
    output logic signed [ANGLE_W-1:0] z_angle,
    output logic                      sample_strobe,
    output logic                      tilt_left,
    output logic                      tilt_right,
    output logic                      tilt_fwd,
    output logic                      tilt_back
);

    localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned SUM_W = 16 + CAL_LOG2;
    localparam int unsigned AW1   = ANGLE_W + 1;

    localparam logic signed [AW1-1:0] A_MAX = AW1'(ANGLE_MAX);
    localparam logic signed [AW1-1:0] A_MIN = -A_MAX;
    localparam logic signed [AW1-1:0] T_ON  = AW1'(TILT_ON);
    localparam logic signed [AW1-1:0] T_OFF = AW1'(TILT_OFF);
    localparam logic signed [16:0]    DB    = 17'(DEADBAND);
    localparam logic signed [16:0]    D_MAX = 17'sd32767;
    localparam logic signed [16:0]    D_MIN = -17'sd32768;

    localparam logic [0:0] ST_CALIB = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]                state, state_next;
    logic [CNT_W-1:0]          tick_cnt;
    logic                      tick;
    logic                      v0, v1;
    logic [CAL_LOG2-1:0]       cal_cnt;
    logic signed [15:0]        axis_in  [3];
    logic signed [15:0]        raw_q    [3];
    logic signed [15:0]        bias_q   [3];
    logic signed [SUM_W-1:0]   sum_q    [3];
    logic signed [SUM_W-1:0]   sum_nx   [3];
    logic signed [15:0]        rate_q   [3];
    logic signed [15:0]        rate_nx  [3];
    logic signed [ANGLE_W-1:0] angle_q  [3];
    logic signed [ANGLE_W-1:0] angle_nx [3];
    logic                      pos_q [2], neg_q [2], pos_nx [2], neg_nx [2];

    assign axis_in[0] = x_axis_data;
    assign axis_in[1] = y_axis_data;
    assign axis_in[2] = z_axis_data;

    assign calibrated = (state == ST_RUN);
    assign x_rate     = rate_q[0];
    assign y_rate     = rate_q[1];
    assign z_rate     = rate_q[2];
    assign x_angle    = angle_q[0];
    assign y_angle    = angle_q[1];
    assign z_angle    = angle_q[2];
    assign tilt_right = pos_q[0];
    assign tilt_left  = neg_q[0];
    assign tilt_fwd   = pos_q[1];
    assign tilt_back  = neg_q[1];

    assign tick = (tick_cnt == CNT_W'(SAMPLE_DIV - 1));

    // Bias subtraction in 17 bits, saturated to 16, then dead-banded.
    function automatic logic signed [15:0] correct(input logic signed [15:0] raw,
                                                   input logic signed [15:0] bias);
        logic signed [16:0] d;
        logic signed [15:0] r;
        d = $signed({raw[15], raw}) - $signed({bias[15], bias});
        if (d > D_MAX)                 r = 16'sh7FFF;
        else if (d < D_MIN)            r = 16'sh8000;
        else if (d <= DB && d >= -DB)  r = '0;
        else                           r = d[15:0];
        return r;
    endfunction

    // Integrate one scaled rate step and clamp to +/-ANGLE_MAX.
    function automatic logic signed [ANGLE_W-1:0] integrate(input logic signed [ANGLE_W-1:0] angle,
                                                            input logic signed [15:0] rate);
        logic signed [15:0]    step;
        logic signed [AW1-1:0] s;
        step = rate >>> RATE_SHIFT;
        s    = $signed({angle[ANGLE_W-1], angle}) + AW1'(step);
        if (s > A_MAX)      s = A_MAX;
        else if (s < A_MIN) s = A_MIN;
        return s[ANGLE_W-1:0];
    endfunction

    function automatic logic flag_pos(input logic signed [ANGLE_W-1:0] a, input logic cur);
        logic signed [AW1-1:0] e;
        logic f;
        e = $signed({a[ANGLE_W-1], a});
        if (e >= T_ON)      f = 1'b1;
        else if (e < T_OFF) f = 1'b0;
        else                f = cur;
        return f;
    endfunction

    function automatic logic flag_neg(input logic signed [ANGLE_W-1:0] a, input logic cur);
        logic signed [AW1-1:0] e;
        logic f;
        e = $signed({a[ANGLE_W-1], a});
        if (e <= -T_ON)      f = 1'b1;
        else if (e > -T_OFF) f = 1'b0;
        else                 f = cur;
        return f;
    endfunction

    // Next-state and per-axis datapath next values.
    always_comb begin
        state_next = state;
        if (recal)
            state_next = ST_CALIB;
        else if (state == ST_CALIB && v0 && cal_cnt == '1)
            state_next = ST_RUN;
        for (int i = 0; i < 3; i++) begin
            sum_nx[i]   = sum_q[i] + SUM_W'(raw_q[i]);
            rate_nx[i]  = correct(raw_q[i], bias_q[i]);
            angle_nx[i] = integrate(angle_q[i], rate_q[i]);
        end
        for (int i = 0; i < 2; i++) begin
            pos_nx[i] = flag_pos(angle_nx[i], pos_q[i]);
            neg_nx[i] = flag_neg(angle_nx[i], neg_q[i]);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_CALIB;
        else     state <= state_next;
    end

    // Tick counter, 3-stage sample pipeline, calibration and integration.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt      <= '0;
            v0            <= 1'b0;
            v1            <= 1'b0;
            sample_strobe <= 1'b0;
            cal_cnt       <= '0;
            for (int i = 0; i < 3; i++) begin
                raw_q[i]   <= '0;
                bias_q[i]  <= '0;
                sum_q[i]   <= '0;
                rate_q[i]  <= '0;
                angle_q[i] <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                pos_q[i] <= 1'b0;
                neg_q[i] <= 1'b0;
            end
        end else begin
            tick_cnt      <= tick ? '0 : tick_cnt + 1'b1;
            v0            <= tick & ~recal;
            v1            <= 1'b0;
            sample_strobe <= v1 & ~recal;
            if (tick) begin
                for (int i = 0; i < 3; i++) raw_q[i] <= axis_in[i];
            end
            if (recal) begin
                // Restart calibration; bias is kept until the new one lands.
                cal_cnt <= '0;
                for (int i = 0; i < 3; i++) begin
                    sum_q[i]   <= '0;
                    rate_q[i]  <= '0;
                    angle_q[i] <= '0;
                end
                for (int i = 0; i < 2; i++) begin
                    pos_q[i] <= 1'b0;
                    neg_q[i] <= 1'b0;
                end
            end else begin
                if (v0 && state == ST_CALIB) begin
                    cal_cnt <= cal_cnt + 1'b1;
                    for (int i = 0; i < 3; i++)
                        sum_q[i] <= (cal_cnt == '1) ? '0 : sum_nx[i];
                    if (cal_cnt == '1) begin
                        for (int i = 0; i < 3; i++) begin
                            bias_q[i]  <= 16'(sum_nx[i] >>> CAL_LOG2);
                            angle_q[i] <= '0;
                        end
                        for (int i = 0; i < 2; i++) begin
                            pos_q[i] <= 1'b0;
                            neg_q[i] <= 1'b0;
                        end
                    end
                end
                if (v0 && state == ST_RUN) begin
                    for (int i = 0; i < 3; i++) rate_q[i] <= rate_nx[i];
                    v1 <= 1'b1;
                end
                // A coincident zero request drops this sample's integration.
                if (state == ST_RUN && zero_angles) begin
                    for (int i = 0; i < 3; i++) angle_q[i] <= '0;
                    for (int i = 0; i < 2; i++) begin
                        pos_q[i] <= 1'b0;
                        neg_q[i] <= 1'b0;
                    end
                end else if (v1) begin
                    for (int i = 0; i < 3; i++) angle_q[i] <= angle_nx[i];
                    for (int i = 0; i < 2; i++) begin
                        pos_q[i] <= pos_nx[i];
                        neg_q[i] <= neg_nx[i];
                    end
                end
            end
        end
    end

endmodule
